// File: rtl/barrel_shift_arbiter_if.sv
// Request/result bundle between two requesters, the result consumer and barrel_shift_arbiter.
// master = requesters and consumer side, slave = arbiter side.
interface barrel_shift_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_data;
  logic       req0_dir;
  logic [2:0] req0_shamt;
  logic       req0_rot;

  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_data;
  logic       req1_dir;
  logic [2:0] req1_shamt;
  logic       req1_rot;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_id;

  modport master (
    output req0_valid, req0_data, req0_dir, req0_shamt, req0_rot,
    output req1_valid, req1_data, req1_dir, req1_shamt, req1_rot,
    output res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_dir, req0_shamt, req0_rot,
    input  req1_valid, req1_data, req1_dir, req1_shamt, req1_rot,
    input  res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter sharing one 8-bit barrel shifter between two requesters.
// Rotates (two shifter passes via PASS2) exist only when BARREL_SHIFT_ARB_ROTATE_EN is defined.
module barrel_shift_arbiter #(
  parameter int unsigned INIT_PRIO = 0
) (
  input logic                   clk,
  input logic                   rst,
  barrel_shift_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPass2, StDone} state_e;

  state_e     state_q;
  logic       prio_q;
  logic       cont_q;
  logic       res_valid_q;
  logic       res_id_q;
  logic [7:0] res_data_q;

  logic       in_idle;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic [7:0] in_data;
  logic       in_dir;
  logic [2:0] in_shamt;

  logic [7:0] sh_data;
  logic       sh_dir;
  logic [2:0] sh_amt;
  logic [7:0] sh_out;

`ifdef BARREL_SHIFT_ARB_ROTATE_EN
  logic       in_rot;
  logic [7:0] data_q;
  logic       dir_q;
  logic [2:0] shamt_q;
  logic [7:0] partial_q;

  assign in_rot = grant1 ? bus.req1_rot : bus.req0_rot;
`else
  logic unused_rot;
  assign unused_rot = bus.req0_rot ^ bus.req1_rot;
`endif

  // Priority holder wins only when both requesters are valid.
  assign in_idle = (state_q == StIdle) && !rst;
  assign grant0  = bus.req0_valid && (!bus.req1_valid || !prio_q);
  assign grant1  = bus.req1_valid && (!bus.req0_valid || prio_q);
  assign accept  = in_idle && (grant0 || grant1);

  assign bus.req0_ready = in_idle && grant0;
  assign bus.req1_ready = in_idle && grant1;

  assign in_data  = grant1 ? bus.req1_data  : bus.req0_data;
  assign in_dir   = grant1 ? bus.req1_dir   : bus.req0_dir;
  assign in_shamt = grant1 ? bus.req1_shamt : bus.req0_shamt;

  // Shared shifter; select inputs idle at zero whenever its output is not sampled.
  always_comb begin
    sh_data = '0;
    sh_dir  = 1'b0;
    sh_amt  = '0;
    if (accept) begin
      sh_data = in_data;
      sh_dir  = in_dir;
      sh_amt  = in_shamt;
    end
`ifdef BARREL_SHIFT_ARB_ROTATE_EN
    else if (state_q == StPass2) begin
      sh_data = data_q;
      sh_dir  = !dir_q;
      sh_amt  = 3'(4'd8 - {1'b0, shamt_q});
    end
`endif
    sh_out = sh_dir ? (sh_data << sh_amt) : (sh_data >> sh_amt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      prio_q      <= INIT_PRIO[0];
      cont_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
`ifdef BARREL_SHIFT_ARB_ROTATE_EN
      data_q      <= '0;
      dir_q       <= 1'b0;
      shamt_q     <= '0;
      partial_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            res_id_q <= grant1;
            cont_q   <= bus.req0_valid && bus.req1_valid;
`ifdef BARREL_SHIFT_ARB_ROTATE_EN
            data_q   <= in_data;
            dir_q    <= in_dir;
            shamt_q  <= in_shamt;
            if (in_rot && (in_shamt != 3'd0)) begin
              partial_q <= sh_out;
              state_q   <= StPass2;
            end else begin
              res_data_q  <= sh_out;
              res_valid_q <= 1'b1;
              state_q     <= StDone;
            end
`else
            res_data_q  <= sh_out;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
`endif
          end
        end
`ifdef BARREL_SHIFT_ARB_ROTATE_EN
        StPass2: begin
          res_data_q  <= partial_q | sh_out;
          res_valid_q <= 1'b1;
          state_q     <= StDone;
        end
`endif
        StDone: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
            // Hand priority over only if the other requester was actually waiting.
            if (cont_q) prio_q <= !res_id_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;

endmodule

// File: doc/barrel_shift_arbiter.md
# barrel_shift_arbiter

Sequencer and arbiter that shares one combinational 8-bit `barrel_shift` unit between two requesters. Each requester submits an operand, direction, amount and shift/rotate flag over a valid/ready handshake. The block grants round-robin, drives the shared shifter for one pass (logical shift) or two passes (rotate), and returns a registered result tagged with the requester ID. It sits between the requesting datapath stages and the shifter instance it owns.

## Interface
- `INIT_PRIO`, default 0: requester holding priority after reset (0 or 1).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid and ready are both high.
- `req0_data` / `req1_data`  in  8  operand.
- `req0_dir` / `req1_dir`  in  1  0 = right, 1 = left; same encoding as `barrel_shift` `dir`.
- `req0_shamt` / `req1_shamt`  in  3  amount, 0–7.
- `req0_rot` / `req1_rot`  in  1  1 = rotate, 0 = logical shift with zero fill.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  8  result.
- `res_id`  out  1  requester that issued the result.

## Operation
- FSM states: IDLE, PASS2, DONE.
- IDLE:
  - The granted requester is the one with `valid` high. If both are high, the priority holder is granted.
  - Only the granted requester sees `ready` = 1. `ready` is combinational from `valid` and the priority pointer, and is 0 outside IDLE.
  - On accept, latch data, dir, shamt, rot and id, and drive the shifter with (data, dir, shamt).
  - If rot = 0, or rot = 1 with shamt = 0: register the shifter output into `res_data`, then go to DONE.
  - Otherwise: register the shifter output into a partial register, then go to PASS2.
- PASS2:
  - Drive the shifter with (latched data, ~dir, 8 − shamt), which always fits in 3 bits.
  - `res_data` = partial | shifter output. Go to DONE.
- DONE:
  - `res_valid` = 1. `res_data` and `res_id` are held stable until `res_ready`.
  - On `res_ready`, go to IDLE and flip the priority pointer to the other requester.
- The pointer flips only on result completion and never when only one requester is active.
- Rotate semantics:
  - Rotate right by k = (d >> k) | (d << (8 − k)).
  - Rotate left by k = (d << k) | (d >> (8 − k)).
- Only one operation is in flight at a time. Requests arriving outside IDLE stall with `ready` = 0 and must be held by the requester.

## Timing
- Reset values:
  - State = IDLE, pointer = `INIT_PRIO`.
  - `res_valid` = 0, `res_data` = 0x00, `res_id` = 0.
  - `req0_ready` = `req1_ready` = 0 during the reset cycle.
- Latency from the accept edge to `res_valid` high: 1 cycle for a shift, 2 cycles for a rotate with nonzero amount.
- Throughput with `res_ready` tied high: one shift every 2 cycles, one rotate every 3 cycles. DONE→IDLE costs one cycle; accept is not permitted in DONE.
- `res_ready` high while `res_valid` is low is ignored.
- Simultaneous valids in IDLE: the grant goes to the pointer holder. The other requester is served next if it is still valid.
- Reset asserted in PASS2 or DONE: the in-flight operation is discarded with no result, and the pointer returns to `INIT_PRIO`.
- The shifter select inputs are driven to zero in IDLE with no accept and in DONE. The shifter output is sampled only on the accept and PASS2 edges.

## Configuration
- `BARREL_SHIFT_ARB_ROTATE_EN` defined:
  - Rotate behaves as described above.
  - The PASS2 state and partial register are present.
- Not defined:
  - `reqN_rot` is ignored. Every request is a logical shift with 1-cycle latency.
  - PASS2 and the partial register are removed.

## Test plan
- Single shift: req0 data 0xB4, dir 0, shamt 2, rot 0 → `res_valid` 1 cycle after accept, `res_data` 0x2D, `res_id` 0.
- Left shift with drop-off: req1 data 0x81, dir 1, shamt 1 → `res_data` 0x02, `res_id` 1.
- Rotate (macro defined):
  - req0 0x81, dir 0, shamt 1, rot 1 → 0xC0 two cycles after accept.
  - req0 0x96, dir 1, shamt 3, rot 1 → 0xB4.
  - Rotate with shamt 0 → data unchanged after 1 cycle.
- Contention:
  - `INIT_PRIO` = 0, both requesters valid continuously, `res_ready` held high → grants alternate 0, 1, 0, 1.
  - The unserved requester's `ready` stays 0 while the other is in flight.
- Backpressure: hold `res_ready` low for 5 cycles in DONE → `res_data` and `res_id` stable, both `ready` signals 0; release → IDLE on the next cycle.
- Reset mid-rotate: assert `rst` in PASS2 → next cycle `res_valid` 0, `res_data` 0x00, pointer = `INIT_PRIO`, and no result is ever produced for that request.
